ascon_round_ctrl: RTL

- FSM sequencer for the ASCON-128 permutation datapath.
- Owns the 4-bit round counter and steps it through p^a (initialisation, finalisation) and p^b (per AD/plaintext block).
- Drives the state-load, key-XOR, data-XOR and domain-separation strobes, and handshakes AD, plaintext and tag with the surrounding wrapper.

---
 rtl/ascon_round_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ascon_round_ctrl.sv
// ascon_round_ctrl: sequencer for the ASCON-128 permutation datapath.
// Steps the 4-bit round counter through p^a (init/final) and p^b (per AD/PT
// block), drives the datapath strobes and handshakes AD, plaintext and tag.
// Optional protocol checker (sticky err_o) is built when the macro
// ASCON_CTRL_PROTO_CHECK_EN is defined.
module ascon_round_ctrl #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       no_ad_i,
  input  logic       ad_valid_i,
  input  logic       ad_last_i,
  output logic       ad_ready_o,
  input  logic       pt_valid_i,
  input  logic       pt_last_i,
  output logic       pt_ready_o,
  input  logic       tag_ready_i,
  output logic [3:0] round_o,
  output logic       perm_en_o,
  output logic       state_load_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_data_begin_o,
  output logic       xor_dom_sep_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
`ifdef ASCON_CTRL_PROTO_CHECK_EN
  ,
  output logic       err_o
`endif
);

  // Round counters always finish at 11, so each permutation begins at
  // 12 - rounds; a single-round permutation starts and ends on round 11.
  localparam logic [3:0] START_A    = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] START_B    = 4'(12 - NB_ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD_WAIT,
    S_AD_PERM,
    S_PT_WAIT,
    S_PT_PERM,
    S_FINAL,
    S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] round_reg, round_next;
  logic       no_ad_reg, no_ad_next;
  logic       ad_last_reg, ad_last_next;
  logic       last_round;

  assign last_round = (round_reg == LAST_ROUND);

  // State register, round counter and latched per-run flags.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg   <= S_IDLE;
      round_reg   <= 4'd0;
      no_ad_reg   <= 1'b0;
      ad_last_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      round_reg   <= round_next;
      no_ad_reg   <= no_ad_next;
      ad_last_reg <= ad_last_next;
    end
  end

  // Next-state, counter update and strobe decode.
  always_comb begin
    state_next       = state_reg;
    round_next       = round_reg;
    no_ad_next       = no_ad_reg;
    ad_last_next     = ad_last_reg;
    perm_en_o        = 1'b0;
    state_load_o     = 1'b0;
    xor_key_begin_o  = 1'b0;
    xor_key_end_o    = 1'b0;
    xor_data_begin_o = 1'b0;
    xor_dom_sep_o    = 1'b0;
    ad_ready_o       = 1'b0;
    pt_ready_o       = 1'b0;
    cipher_valid_o   = 1'b0;
    tag_valid_o      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next   = S_INIT;
          round_next   = START_A;
          no_ad_next   = no_ad_i;
          ad_last_next = 1'b0;
        end
      end

      S_INIT: begin
        perm_en_o    = 1'b1;
        state_load_o = (round_reg == START_A);
        round_next   = round_reg + 4'd1;
        if (last_round) begin
          xor_key_end_o = 1'b1;
          round_next    = 4'd0;
          if (no_ad_reg) begin
            xor_dom_sep_o = 1'b1;
            state_next    = S_PT_WAIT;
          end else begin
            state_next    = S_AD_WAIT;
          end
        end
      end

      S_AD_WAIT: begin
        ad_ready_o = 1'b1;
        if (ad_valid_i) begin
          state_next   = S_AD_PERM;
          round_next   = START_B;
          ad_last_next = ad_last_i;
        end
      end

      S_AD_PERM: begin
        perm_en_o        = 1'b1;
        xor_data_begin_o = (round_reg == START_B);
        round_next       = round_reg + 4'd1;
        if (last_round) begin
          round_next = 4'd0;
          if (ad_last_reg) begin
            xor_dom_sep_o = 1'b1;
            state_next    = S_PT_WAIT;
          end else begin
            state_next    = S_AD_WAIT;
          end
        end
      end

      S_PT_WAIT: begin
        pt_ready_o = 1'b1;
        if (pt_valid_i) begin
          cipher_valid_o = 1'b1;
          if (pt_last_i) begin
            state_next = S_FINAL;
            round_next = START_A;
          end else begin
            state_next = S_PT_PERM;
            round_next = START_B;
          end
        end
      end

      S_PT_PERM: begin
        perm_en_o        = 1'b1;
        xor_data_begin_o = (round_reg == START_B);
        round_next       = round_reg + 4'd1;
        if (last_round) begin
          round_next = 4'd0;
          state_next = S_PT_WAIT;
        end
      end

      S_FINAL: begin
        perm_en_o        = 1'b1;
        xor_data_begin_o = (round_reg == START_A);
        xor_key_begin_o  = (round_reg == START_A);
        round_next       = round_reg + 4'd1;
        if (last_round) begin
          xor_key_end_o = 1'b1;
          round_next    = 4'd0;
          state_next    = S_DONE;
        end
      end

      S_DONE: begin
        tag_valid_o = 1'b1;
        if (tag_ready_i) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
        round_next = 4'd0;
      end
    endcase
  end

  assign round_o = round_reg;
  assign busy_o  = (state_reg != S_IDLE);

`ifdef ASCON_CTRL_PROTO_CHECK_EN
  logic err_reg;
  logic violation;

  // Misuse of the handshake inputs: AD offered during an AD permutation,
  // plaintext offered before the AD phase is over, or a restart while busy.
  always_comb begin
    violation = 1'b0;
    if (ad_valid_i && (state_reg == S_AD_PERM) && !no_ad_reg)
      violation = 1'b1;
    if (pt_valid_i && ((state_reg == S_AD_WAIT) || (state_reg == S_AD_PERM) ||
                       (state_reg == S_INIT)))
      violation = 1'b1;
    if (start_i && busy_o)
      violation = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      err_reg <= 1'b0;
    end else if (violation) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`endif

endmodule
